// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer for the shared 12x12 shift-add multiplier.
// Optional RUN timeout with error response: define MUL_ARB_TIMEOUT_EN.
module mul_arbiter #(
   parameter int unsigned FLUSH_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 20,
   localparam int unsigned OP_W   = 12,
   localparam int unsigned PROD_W = 24
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [OP_W-1:0]   a0,
   input  logic [OP_W-1:0]   a1,
   input  logic [OP_W-1:0]   b0,
   input  logic [OP_W-1:0]   b1,
   output logic              ack0,
   output logic              ack1,
   output logic              done0,
   output logic              done1,
   output logic [PROD_W-1:0] rsp_product,
   output logic              rsp_err,
   output logic              mul_start,
   output logic [OP_W-1:0]   mul_multiplier,
   output logic [OP_W-1:0]   mul_multiplicand,
   input  logic [PROD_W-1:0] mul_product,
   input  logic              mul_finished
);
   localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES);

   if (FLUSH_CYCLES < 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mul_arbiter: FLUSH_CYCLES must be >= 15 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_RUN, S_DONE, S_COOL} state_t;

   state_t             state;
   logic [FLUSH_W-1:0] flush_cnt;
   logic               last_grant;
   logic               owner;
   logic               pick1_c;

   // On a tie the client that was not granted last wins.
   assign pick1_c = (req0 && req1) ? !last_grant : req1;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             aborted;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= S_FLUSH;
         flush_cnt        <= '0;
         last_grant       <= 1'b1;
         owner            <= 1'b0;
         ack0             <= 1'b0;
         ack1             <= 1'b0;
         done0            <= 1'b0;
         done1            <= 1'b0;
         rsp_product      <= '0;
         mul_start        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         rsp_err          <= 1'b0;
         tmo_cnt          <= '0;
         aborted          <= 1'b0;
`endif
      end else begin
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            // Multiplier has no reset: keep start low long enough to drain it.
            S_FLUSH: begin
               mul_start <= 1'b0;
               if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                  flush_cnt <= '0;
                  state     <= S_IDLE;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_W'(1);
               end
            end
            S_IDLE: begin
               if (req0 || req1) begin
                  owner            <= pick1_c;
                  last_grant       <= pick1_c;
                  ack0             <= !pick1_c;
                  ack1             <= pick1_c;
                  mul_multiplier   <= pick1_c ? a1 : a0;
                  mul_multiplicand <= pick1_c ? b1 : b0;
                  mul_start        <= 1'b1;
                  state            <= S_RUN;
`ifdef MUL_ARB_TIMEOUT_EN
                  tmo_cnt          <= '0;
`endif
               end
            end
            S_RUN: begin
               if (mul_finished) begin
                  rsp_product <= mul_product;
                  done0       <= !owner;
                  done1       <= owner;
                  mul_start   <= 1'b0;
                  state       <= S_DONE;
`ifdef MUL_ARB_TIMEOUT_EN
                  rsp_err     <= 1'b0;
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                  rsp_product <= '0;
                  rsp_err     <= 1'b1;
                  aborted     <= 1'b1;
                  done0       <= !owner;
                  done1       <= owner;
                  mul_start   <= 1'b0;
                  state       <= S_DONE;
               end else begin
                  tmo_cnt     <= tmo_cnt + TMO_W'(1);
`endif
               end
            end
            S_DONE: begin
`ifdef MUL_ARB_TIMEOUT_EN
               aborted <= 1'b0;
               state   <= aborted ? S_FLUSH : S_COOL;
`else
               state   <= S_COOL;
`endif
            end
            // Lets the multiplier leave its extra post-finish state.
            S_COOL:  state <= S_IDLE;
            default: state <= S_FLUSH;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: timestamp-based reference model, multiplier stub,
// directed scenarios with literal expectations.
module tb_mul_arbiter;
   localparam int FLUSH_CYCLES   = 16;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int FIN_LAT        = 14;
   localparam int WAIT_LIMIT     = 200;

   logic        clock, reset_n;
   logic        req0, req1;
   logic [11:0] a0, a1, b0, b1;
   logic        ack0, ack1, done0, done1;
   logic [23:0] rsp_product;
   logic        rsp_err;
   logic        mul_start;
   logic [11:0] mul_multiplier, mul_multiplicand;
   logic [23:0] mul_product;
   logic        mul_finished;

   int checks = 0;
   int errors = 0;

   mul_arbiter #(.FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_multiplier(mul_multiplier),
      .mul_multiplicand(mul_multiplicand),
      .mul_product(mul_product), .mul_finished(mul_finished)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Shift-add multiplier stub: loads on start, 12 shift cycles, then done.
   typedef enum int {M_IDLE, M_SHIFT, M_DONE, M_EXTRA} mst_t;
   mst_t        m_state = M_IDLE;
   int          m_cnt = 0;
   logic [23:0] m_prod = '0;
   logic        stall = 1'b0;
   assign mul_product  = m_prod;
   assign mul_finished = (m_state == M_DONE) && !stall;

   always @(posedge clock) begin
      case (m_state)
         M_IDLE: if (mul_start) begin
            m_prod  <= 24'(mul_multiplier) * 24'(mul_multiplicand);
            m_cnt   <= 0;
            m_state <= M_SHIFT;
         end
         M_SHIFT: if (m_cnt == 11) m_state <= M_DONE; else m_cnt <= m_cnt + 1;
         M_DONE: begin
            if (!mul_start) m_state <= M_IDLE;
            else if (!stall) m_state <= M_EXTRA;
         end
         default: m_state <= M_IDLE;
      endcase
   end

   // Reference model: edge numbers and timestamps of grant/finish/free.
   int          n = 0;
   int          free_at = 0;
   int          g = 0;
   bit          busy = 0;
   bit          own = 0;
   bit          last_m = 1;
   bit          stall_op = 0;
   logic [23:0] op_prod = '0;
   logic        e_ack0, e_ack1, e_done0, e_done1, e_err, e_start;
   logic [23:0] e_prod;
   logic [11:0] e_mplr, e_mcnd;

   always @(posedge clock) begin
      n++;
      e_ack0 = 0; e_ack1 = 0; e_done0 = 0; e_done1 = 0;
      if (!reset_n) begin
         busy = 0; last_m = 1; free_at = n + FLUSH_CYCLES + 1;
         e_prod = '0; e_err = 0; e_start = 0; e_mplr = '0; e_mcnd = '0;
      end else begin
         if (busy && !stall_op && n == g + FIN_LAT) begin
            busy = 0; e_start = 0; e_prod = op_prod; e_err = 0;
            if (own) e_done1 = 1; else e_done0 = 1;
         end
`ifdef MUL_ARB_TIMEOUT_EN
         else if (busy && n == g + TIMEOUT_CYCLES + 1) begin
            busy = 0; e_start = 0; e_prod = '0; e_err = 1;
            if (own) e_done1 = 1; else e_done0 = 1;
            free_at = g + TIMEOUT_CYCLES + 2 + FLUSH_CYCLES + 1;
         end
`endif
         if (!busy && n >= free_at && (req0 || req1)) begin
            if (req0 && req1) own = !last_m; else own = req1;
            last_m = own; g = n; busy = 1; stall_op = stall;
            e_start = 1;
            if (own) begin e_ack1 = 1; e_mplr = a1; e_mcnd = b1; end
            else     begin e_ack0 = 1; e_mplr = a0; e_mcnd = b0; end
            op_prod = 24'(e_mplr) * 24'(e_mcnd);
            free_at = g + FIN_LAT + 3;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask

   logic prev_start = 1'b0;
   task automatic compare_outputs();
      if (n > 0) begin
         chk("ack0", 32'(ack0), 32'(e_ack0));
         chk("ack1", 32'(ack1), 32'(e_ack1));
         chk("done0", 32'(done0), 32'(e_done0));
         chk("done1", 32'(done1), 32'(e_done1));
         chk("rsp_product", 32'(rsp_product), 32'(e_prod));
         chk("rsp_err", 32'(rsp_err), 32'(e_err));
         chk("mul_start", 32'(mul_start), 32'(e_start));
         chk("mul_multiplier", 32'(mul_multiplier), 32'(e_mplr));
         chk("mul_multiplicand", 32'(mul_multiplicand), 32'(e_mcnd));
         if (mul_start && !prev_start)
            chk("start_while_mul_idle", 32'(m_state == M_IDLE), 32'd1);
         prev_start = mul_start;
      end
   endtask

   bit sticky0 = 0, sticky1 = 0;
   task automatic step();
      @(negedge clock);
      compare_outputs();
      @(posedge clock);
      #2;
      if (ack0 && !sticky0) req0 = 1'b0;
      if (ack1 && !sticky1) req1 = 1'b0;
   endtask

   function automatic logic pulse(input int sel);
      case (sel)
         0: return ack0;
         1: return ack1;
         2: return done0;
         3: return done1;
         default: return done0 | done1;
      endcase
   endfunction

   task automatic wait_pulse(input string name, input int sel, output int steps);
      steps = 0;
      do begin step(); steps++; end while (!pulse(sel) && steps < WAIT_LIMIT);
      if (!pulse(sel)) begin
         checks++; errors++;
         $display("FAIL %s: no pulse after %0d cycles", name, steps);
      end
   endtask

   initial begin
      int s, s2;
      logic [23:0] exp_p;
      reset_n = 1'b0; req0 = 0; req1 = 0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      repeat (3) step();
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_rsp_product", 32'(rsp_product), 32'd0);

      // Single request straight out of reset
      req0 = 1; a0 = 12'h003; b0 = 12'h005; reset_n = 1'b1;
      wait_pulse("t1_ack0", 0, s);
      chk("t1_first_ack_cycles", 32'(s), 32'(FLUSH_CYCLES + 1));
      chk("t1_operand", 32'(mul_multiplier), 32'h003);
      wait_pulse("t1_done0", 2, s);
      chk("t1_latency", 32'(s), 32'd14);
      chk("t1_product", 32'(rsp_product), 32'h00000F);
      chk("t1_err", 32'(rsp_err), 32'd0);

      // Both held from reset: 0,1,0,1 every 17 cycles
      reset_n = 1'b0; step(); step();
      sticky0 = 1; sticky1 = 1; req0 = 1; req1 = 1;
      a0 = 12'hFFF; b0 = 12'hFFF; a1 = 12'h010; b1 = 12'h010;
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_pulse("t2_done", 4, s);
         chk("t2_owner", 32'(done1), 32'(k % 2));
         exp_p = (k % 2 == 0) ? 24'hFFE001 : 24'h000100;
         chk("t2_product", 32'(rsp_product), 32'(exp_p));
         if (k > 0) chk("t2_spacing", 32'(s), 32'd17);
      end
      sticky0 = 0; sticky1 = 0; req0 = 0; req1 = 0;

      // req1 arrives during client 0's RUN
      repeat (3) step();
      req0 = 1; a0 = 12'h123; b0 = 12'h456;
      wait_pulse("t3_ack0", 0, s);
      repeat (4) step();
      req1 = 1; a1 = 12'hABC; b1 = 12'h002;
      wait_pulse("t3_done0", 2, s);
      chk("t3_product0", 32'(rsp_product), 32'h04EDC2);
      wait_pulse("t3_ack1", 1, s2);
      chk("t3_ack1_after_done0", 32'(s2), 32'd3);
      wait_pulse("t3_done1", 3, s);
      chk("t3_product1", 32'(rsp_product), 32'h001578);

      // Reset in cycle 5 of RUN, req0 pending
      repeat (2) step();
      req0 = 1; a0 = 12'h007; b0 = 12'h009;
      wait_pulse("t4_ack0", 0, s);
      repeat (4) step();
      reset_n = 1'b0; req0 = 1;
      step();
      chk("t4_rst_start", 32'(mul_start), 32'd0);
      chk("t4_rst_product", 32'(rsp_product), 32'd0);
      chk("t4_rst_mplr", 32'(mul_multiplier), 32'd0);
      chk("t4_rst_done", 32'(done0 | done1), 32'd0);
      step();
      reset_n = 1'b1;
      wait_pulse("t4_ack0_again", 0, s);
      chk("t4_ack_after_release", 32'(s), 32'(FLUSH_CYCLES + 1));
      wait_pulse("t4_done0", 2, s);
      chk("t4_product", 32'(rsp_product), 32'h00003F);

      // Multiplier never finishes
      repeat (2) step();
      stall = 1; req1 = 1; a1 = 12'h005; b1 = 12'h005;
      wait_pulse("t5_ack1", 1, s);
`ifdef MUL_ARB_TIMEOUT_EN
      wait_pulse("t5_done1", 3, s);
      chk("t5_timeout_cycles", 32'(s), 32'(TIMEOUT_CYCLES + 1));
      chk("t5_err", 32'(rsp_err), 32'd1);
      chk("t5_product", 32'(rsp_product), 32'd0);
      stall = 0; req0 = 1; a0 = 12'h002; b0 = 12'h003;
      wait_pulse("t5_ack0", 0, s2);
      chk("t5_flush_after_abort", 32'(s2), 32'(FLUSH_CYCLES + 2));
      wait_pulse("t5_done0", 2, s);
      chk("t5_product0", 32'(rsp_product), 32'h000006);
`else
      for (int k = 0; k < 100; k++) begin
         step();
         chk("t5_start_held", 32'(mul_start), 32'd1);
      end
      reset_n = 1'b0; step();
      stall = 0; reset_n = 1'b1;
      repeat (20) step();
`endif
      repeat (5) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
